// File: rtl/wave_playback_seq.sv
// wave_playback_seq: read-side sequencer for the asymmetric waveform RAM.
// Walks the narrow read port from a programmable start address for a
// programmable length. It delays an issue flag by the RAM read latency so
// each captured sample leaves aligned with dout_valid.
// Optional build macro: WAVE_PLAYBACK_LOOP_EN adds the 'loop' input. With it,
// playback restarts at start_addr without a gap at the end of each pass.
module wave_playback_seq #(
  parameter int ADDRWIDTH    = 10,
  parameter int DATAWIDTH    = 4,
  parameter int LENWIDTH     = 11,
  parameter int READ_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDRWIDTH-1:0] start_addr,
  input  logic [LENWIDTH-1:0]  length,
`ifdef WAVE_PLAYBACK_LOOP_EN
  input  logic                 loop,
`endif
  output logic [ADDRWIDTH-1:0] ram_addr,
  input  logic [DATAWIDTH-1:0] ram_dout,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seqState_t;

  seqState_t                state;
  logic [ADDRWIDTH-1:0]     startAddrQ;
  logic [LENWIDTH-1:0]      lenQ;
  logic [LENWIDTH-1:0]      issueCnt;
  // issueQ marks that ram_addr currently holds a freshly issued address.
  logic                     issueQ;
  logic [READ_LATENCY-1:0]  validPipe;
  // A zero-length start still owes one done pulse on the following cycle.
  logic                     zeroPend;
  logic                     loopReq;
  logic                     pipeEmpty;
  logic                     lastIssue;

`ifdef WAVE_PLAYBACK_LOOP_EN
  assign loopReq = loop;
`else
  assign loopReq = 1'b0;
`endif

  // Nothing issued and nothing still travelling through the read latency.
  assign pipeEmpty = !issueQ && (validPipe == '0);
  assign lastIssue = (issueCnt == lenQ - LENWIDTH'(1));

  // Sequencer FSM, issue counter, latency pipeline and registered outputs.
  // NOTE: every state register here uses <= so all of them update from the
  // same pre-edge values; a blocking '=' would let later lines see new values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      startAddrQ <= '0;
      lenQ       <= '0;
      issueCnt   <= '0;
      issueQ     <= 1'b0;
      validPipe  <= '0;
      zeroPend   <= 1'b0;
      ram_addr   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort) begin
      // Abort flushes everything in flight; dout and ram_addr keep their values.
      state      <= IDLE;
      issueQ     <= 1'b0;
      validPipe  <= '0;
      zeroPend   <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      validPipe <= (validPipe << 1) | READ_LATENCY'(issueQ);
      if (validPipe[READ_LATENCY-1]) begin
        dout       <= ram_dout;
        dout_valid <= 1'b1;
      end else begin
        dout_valid <= 1'b0;
      end
      done     <= 1'b0;
      zeroPend <= 1'b0;
      issueQ   <= 1'b0;

      case (state)
        IDLE: begin
          if (zeroPend) done <= 1'b1;
          if (start) begin
            if (length != '0) begin
              startAddrQ <= start_addr;
              lenQ       <= length;
              issueCnt   <= '0;
              state      <= RUN;
            end else begin
              zeroPend <= 1'b1;
            end
          end
        end

        RUN: begin
          busy     <= 1'b1;
          issueQ   <= 1'b1;
          // A zero count means the first word of a pass; otherwise step and wrap silently.
          ram_addr <= (issueCnt == '0) ? startAddrQ : ram_addr + ADDRWIDTH'(1);
          if (lastIssue) begin
            issueCnt <= '0;
            if (!loopReq) state <= DRAIN;
          end else begin
            issueCnt <= issueCnt + LENWIDTH'(1);
          end
        end

        DRAIN: begin
          if (pipeEmpty) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_playback_seq.sv
// tb_wave_playback_seq: directed bench for wave_playback_seq with a
// three-stage RAM read model (RAM[i] = i[3:0]). Expected samples and done
// pulses are queued by the stimulus and consumed by an independent monitor.
module tb_wave_playback_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        abort;
  logic [9:0]  start_addr;
  logic [10:0] length;
`ifdef WAVE_PLAYBACK_LOOP_EN
  logic        loop;
`endif
  logic [9:0]  ram_addr;
  logic [3:0]  ram_dout;
  logic [3:0]  dout;
  logic        dout_valid;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [3:0] data;
    int         at;
  } sample_t;

  sample_t expQ[$];
  int      doneQ[$];

  logic [9:0] expAddr[8];
  logic [3:0] expData[8];

  wave_playback_seq #(
    .ADDRWIDTH(10), .DATAWIDTH(4), .LENWIDTH(11), .READ_LATENCY(3)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .start_addr(start_addr), .length(length),
`ifdef WAVE_PLAYBACK_LOOP_EN
    .loop(loop),
`endif
    .ram_addr(ram_addr), .ram_dout(ram_dout), .dout(dout),
    .dout_valid(dout_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM read port model: three cycles from address to data.
  logic [3:0] mem [1024];
  logic [3:0] rd1, rd2, rd3;
  initial for (int i = 0; i < 1024; i++) mem[i] = 4'(i);
  always @(posedge clk) begin
    rd1 <= mem[ram_addr];
    rd2 <= rd1;
    rd3 <= rd2;
  end
  assign ram_dout = rd3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: consumes expected samples and done pulses as the DUT presents them.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (dout_valid) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got dout=%0h at cycle %0d, required none", dout, cyc);
        end else begin
          sample_t e;
          e = expQ.pop_front();
          check("sample_data", dout, e.data);
          check("sample_cycle", cyc, e.at);
        end
      end
      if (done) begin
        if (doneQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
        end else begin
          check("done_cycle", cyc, doneQ.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Pulse start for one cycle; k is the edge that samples it.
  task automatic pulseStart(input logic [9:0] a, input logic [10:0] n, output int k);
    start      = 1'b1;
    start_addr = a;
    length     = n;
    k          = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  // Single pass of n<=8 words with per-edge checks of ram_addr and busy.
  task automatic runPlay(input logic [9:0] a, input logic [10:0] n);
    int k;
    int ni;
    ni = int'(n);
    pulseStart(a, n, k);
    for (int i = 0; i < ni; i++) expQ.push_back('{data: expData[i], at: k + 5 + i});
    doneQ.push_back(k + ni + 5);
    check("busy_at_start_edge", busy, 0);
    for (int e = 1; e <= ni + 6; e++) begin
      tick();
      check("ram_addr", ram_addr, (e <= ni) ? expAddr[e-1] : expAddr[ni-1]);
      check("busy", busy, (e <= ni + 4) ? 1 : 0);
    end
  endtask

  initial begin
    int k;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; start_addr = '0; length = '0;
`ifdef WAVE_PLAYBACK_LOOP_EN
    loop = 1'b0;
`endif
    tick(); tick();
    check("rst_ram_addr", ram_addr, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rstn = 1'b1;
    tick(); tick();

    // Basic pass: 0x010, four words.
    expAddr = '{10'h010, 10'h011, 10'h012, 10'h013, 0, 0, 0, 0};
    expData = '{4'h0, 4'h1, 4'h2, 4'h3, 0, 0, 0, 0};
    runPlay(10'h010, 11'd4);
    tick();

    // Address wrap through all-ones.
    expAddr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 0, 0, 0, 0};
    expData = '{4'hE, 4'hF, 4'h0, 4'h1, 0, 0, 0, 0};
    runPlay(10'h3FE, 11'd4);
    tick();

    // Zero length: only a done pulse, one cycle after the start edge.
    pulseStart(10'h155, 11'd0, k);
    doneQ.push_back(k + 1);
    check("len0_busy_k", busy, 0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      check("len0_ram_addr", ram_addr, 10'h001);
      check("len0_busy", busy, 0);
    end

    // Second start while busy has no effect.
    pulseStart(10'h020, 11'd3, k);
    expQ.push_back('{data: 4'h0, at: k + 5});
    expQ.push_back('{data: 4'h1, at: k + 6});
    expQ.push_back('{data: 4'h2, at: k + 7});
    doneQ.push_back(k + 8);
    tick();
    start = 1'b1; start_addr = 10'h100; length = 11'd2;
    tick();
    start = 1'b0;
    for (int e = 3; e <= 10; e++) tick();
    check("ignored_start_ram_addr", ram_addr, 10'h022);
    check("ignored_start_busy", busy, 0);

    // Abort on the second valid sample of an eight-word run.
    pulseStart(10'h020, 11'd8, k);
    expQ.push_back('{data: 4'h0, at: k + 5});
    expQ.push_back('{data: 4'h1, at: k + 6});
    for (int e = 1; e <= 6; e++) tick();
    check("abort_second_valid", dout_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid_low", dout_valid, 0);
    check("abort_busy_low", busy, 0);
    check("abort_dout_holds", dout, 4'h1);
    for (int e = 0; e < 12; e++) tick();
    check("abort_still_idle", busy, 0);

    // Abort and start together: start is dropped.
    start = 1'b1; abort = 1'b1; start_addr = 10'h040; length = 11'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int e = 0; e < 8; e++) tick();
    check("abort_start_busy", busy, 0);
    check("abort_start_ram_addr", ram_addr, 10'h025);

`ifdef WAVE_PLAYBACK_LOOP_EN
    // Three passes of three words, looping twice.
    begin
      logic [9:0] loopAddr[9];
      loopAddr = '{10'h030, 10'h031, 10'h032, 10'h030, 10'h031, 10'h032, 10'h030, 10'h031, 10'h032};
      loop = 1'b1;
      pulseStart(10'h030, 11'd3, k);
      for (int i = 0; i < 9; i++) expQ.push_back('{data: 4'(i % 3), at: k + 5 + i});
      doneQ.push_back(k + 14);
      for (int e = 1; e <= 16; e++) begin
        tick();
        if (e == 6) loop = 1'b0;
        check("loop_ram_addr", ram_addr, (e <= 9) ? loopAddr[e-1] : 10'h032);
        check("loop_busy", busy, (e <= 13) ? 1 : 0);
      end
    end
`endif

    // Asynchronous reset in the middle of a run.
    pulseStart(10'h050, 11'd4, k);
    tick(); tick();
    check("pre_reset_busy", busy, 1);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_ram_addr", ram_addr, 0);
    check("async_rst_dout", dout, 0);
    check("async_rst_valid", dout_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    tick();
    rstn = 1'b1;
    for (int e = 0; e < 10; e++) tick();
    check("post_rst_valid", dout_valid, 0);
    check("post_rst_busy", busy, 0);

    check("samples_outstanding", expQ.size(), 0);
    check("dones_outstanding", doneQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
